// File: rtl/data_2_tx.sv
// data_2_tx: serial transmit path with a one-byte holding buffer, LSB-first shifting
// paced by bit_strobe. Optional bit stuffing is enabled by defining BIT_STUFF_EN.
module data_2_tx #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                bit_strobe,
  input  logic                clear,
  input  logic                load_en,
  input  logic [NUM_BITS-1:0] tx_data,
  output logic                tx_ready,
  output logic                tx_busy,
  output logic                serial_out,
  output logic                byte_sent
);

  localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef BIT_STUFF_EN
  localparam logic [1:0] STUFF = 2'd2;
`endif

  logic [1:0]          state_q, state_d;
  logic [NUM_BITS-1:0] hold_q, hold_d;
  logic                full_q, full_d;
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                serial_q, serial_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                sent_q, sent_d;
  logic                accept_s;
  logic                reload_s;
`ifdef BIT_STUFF_EN
  logic [2:0]          ones_q, ones_d;
  logic                stuff_last_q, stuff_last_d;
`endif

  // Next-state logic: clear dominates, then per-state shifting and byte hand-over.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    full_d   = full_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    sent_d   = 1'b0;
    reload_s = 1'b0;
    accept_s = load_en && !full_q;
`ifdef BIT_STUFF_EN
    ones_d       = ones_q;
    stuff_last_d = stuff_last_q;
`endif
    if (clear) begin
      state_d = IDLE;
      full_d  = 1'b0;
      cnt_d   = {CW{1'b0}};
`ifdef BIT_STUFF_EN
      ones_d       = 3'd0;
      stuff_last_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            sr_d    = tx_data;
            cnt_d   = {CW{1'b0}};
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (accept_s) begin
            hold_d = tx_data;
            full_d = 1'b1;
          end else begin
            hold_d = hold_q;
          end
          if (bit_strobe) begin
            if (cnt_q == LAST_BIT) begin
              sent_d = 1'b1;
            end else begin
              sr_d  = sr_q >> 1;
              cnt_d = cnt_q + CW'(1);
            end
`ifdef BIT_STUFF_EN
            ones_d = sr_q[0] ? (ones_q + 3'd1) : 3'd0;
            // Six ones in a row: insert a zero, remembering whether the byte is done.
            if (ones_d == 3'd6) begin
              state_d      = STUFF;
              ones_d       = 3'd0;
              stuff_last_d = (cnt_q == LAST_BIT);
            end else begin
              reload_s = (cnt_q == LAST_BIT);
            end
`else
            reload_s = (cnt_q == LAST_BIT);
`endif
          end else begin
            reload_s = 1'b0;
          end
        end
`ifdef BIT_STUFF_EN
        STUFF: begin
          if (accept_s) begin
            hold_d = tx_data;
            full_d = 1'b1;
          end else begin
            hold_d = hold_q;
          end
          if (bit_strobe) begin
            state_d  = SHIFT;
            reload_s = stuff_last_q;
          end else begin
            reload_s = 1'b0;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
      // End of a byte: buffered byte first, then a same-cycle load, else go idle.
      if (reload_s) begin
        cnt_d = {CW{1'b0}};
        if (full_q) begin
          sr_d   = hold_q;
          full_d = 1'b0;
        end else if (load_en) begin
          sr_d   = tx_data;
          full_d = 1'b0;
        end else begin
          state_d = IDLE;
`ifdef BIT_STUFF_EN
          ones_d = 3'd0;
`endif
        end
      end else begin
        cnt_d = cnt_d;
      end
    end
    case (state_d)
      SHIFT:   serial_d = sr_d[0];
`ifdef BIT_STUFF_EN
      STUFF:   serial_d = 1'b0;
`endif
      default: serial_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = !full_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      hold_q   <= {NUM_BITS{1'b0}};
      full_q   <= 1'b0;
      sr_q     <= {NUM_BITS{1'b0}};
      cnt_q    <= {CW{1'b0}};
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      sent_q   <= 1'b0;
`ifdef BIT_STUFF_EN
      ones_q       <= 3'd0;
      stuff_last_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      full_q   <= full_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      sent_q   <= sent_d;
`ifdef BIT_STUFF_EN
      ones_q       <= ones_d;
      stuff_last_q <= stuff_last_d;
`endif
    end
  end

  assign serial_out = serial_q;
  assign tx_busy    = busy_q;
  assign tx_ready   = ready_q;
  assign byte_sent  = sent_q;

endmodule

// File: doc/data_2_tx.md
# data_2_tx

Serial transmit data path for the USB bulk-transfer datapath. It is the transmit-side counterpart of the receive path (`data_2_rx`). The block accepts bytes over a ready/load handshake into a one-byte holding buffer. It shifts each byte out LSB-first, one bit per `bit_strobe`, with optional bit stuffing. The output feeds the downstream line encoder (NRZI/driver).

## Interface
- NUM_BITS, 8, data bits per transfer unit (byte)
- clk  in  1  system clock; all logic on rising edge
- n_rst  in  1  reset, synchronous, active-low
- bit_strobe  in  1  one-cycle pulse marking the end of the current bit period (from the bit-rate timer)
- clear  in  1  synchronous abort; flushes buffer and shifter
- load_en  in  1  write strobe for `tx_data`; accepted only when `tx_ready`=1
- tx_data  in  NUM_BITS  byte to send
- tx_ready  out  1  holding buffer empty; a load is accepted this cycle
- tx_busy  out  1  a byte (or stuff bit) is on the line
- serial_out  out  1  NRZ bit to the line encoder; idle level 1
- byte_sent  out  1  one-cycle pulse at the strobe completing a byte's last data bit

## Operation
- Storage:
  - holding buffer `buf[NUM_BITS-1:0]` with `buf_full` flag
  - shift register `sr`
  - bit counter `bit_cnt`, width clog2(NUM_BITS)
  - ones counter `ones_cnt`, 3 bits
- States: IDLE, SHIFT, STUFF (STUFF exists only with the macro enabled).
- IDLE:
  - `serial_out`=1, `tx_busy`=0.
  - An accepted load goes directly into `sr`, `bit_cnt`=0, next state SHIFT; the buffer stays empty.
- SHIFT:
  - `serial_out`=`sr[0]`.
  - An accepted load writes `buf` and sets `buf_full`.
  - On `bit_strobe` with `bit_cnt`<NUM_BITS-1: shift `sr` right and increment `bit_cnt`.
  - On `bit_strobe` with `bit_cnt`=NUM_BITS-1: pulse `byte_sent`, then take the next byte in this priority order:
    - (a) if `buf_full`, move `buf` into `sr` and clear `buf_full`;
    - (b) else if `load_en` is high this cycle, load `tx_data` straight into `sr`;
    - (c) else go to IDLE.
  - Cases (a) and (b) set `bit_cnt`=0 and produce no idle gap.
- `tx_ready` = !`buf_full`.
- `load_en` while `tx_ready`=0 is ignored; the buffer contents are unchanged.
- `clear`:
  - Takes priority over every action except reset. Next state IDLE; `buf_full`, `bit_cnt` and `ones_cnt` go to 0; `serial_out`=1.
  - No `byte_sent` pulse. A `load_en` in the same cycle is discarded.
- `bit_strobe` in IDLE has no effect.

## Timing
- Reset values: `serial_out`=1, `tx_ready`=1, `tx_busy`=0, `byte_sent`=0. State IDLE; all counters 0.
- Reset mid-byte drops the byte without a `byte_sent` pulse.
- Load latency:
  - Load in IDLE at edge N: `serial_out`=bit0 from N+1.
  - Each bit is held until the next `bit_strobe`; the first bit may therefore be shorter than a full period.
- `byte_sent` is high for exactly the cycle after the final data-bit strobe edge, i.e. registered.
- Back-to-back bytes: bit0 of the next byte appears the cycle after the last strobe of the previous byte.
- Load and the last-bit strobe in the same cycle with an empty buffer: the byte goes straight to `sr`. It must not pass through `buf`, so there is no one-cycle idle glitch.

## Configuration
- `BIT_STUFF_EN` defined: bit stuffing is active.
  - On each strobe in SHIFT, `ones_cnt` increments if `serial_out`=1, else it clears.
  - When a strobe makes `ones_cnt` reach 6, enter STUFF: `serial_out`=0 for one bit period, `ones_cnt`=0, `bit_cnt` and `sr` held.
  - On the STUFF-ending strobe, return to SHIFT. If the stuff followed the last data bit, apply the SHIFT reload rules (a)/(b)/(c) at that strobe instead.
  - `byte_sent` still pulses at the last data-bit strobe, before the stuff bit.
  - `ones_cnt` carries across bytes in a back-to-back run; it clears on entering IDLE.
  - `tx_busy`=1 in STUFF.
- `BIT_STUFF_EN` undefined: there is no STUFF state and no `ones_cnt`. Exactly NUM_BITS bit periods are sent per byte.

## Test plan
- Reset, then load 0xA5 in IDLE:
  - `serial_out` sequence 1,0,1,0,0,1,0,1 across 8 strobes.
  - `byte_sent` pulses once after the 8th strobe.
  - `serial_out` returns to 1 and `tx_busy`=0.
- Back-to-back bytes: load 0x3C, then 0xC3 while shifting (`tx_ready` drops to 0):
  - 16 contiguous bits 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1.
  - Two `byte_sent` pulses; no idle cycle between bytes.
- Load 0xFF:
  - With `BIT_STUFF_EN`: bits 1×6, 0 (stuff), 1,1. `byte_sent` after the 9th strobe overall (8th data bit); idle after 9 bit periods.
  - Without the macro: 8 ones.
- Buffer full: a third `load_en` (0x11) while `tx_ready`=0 is ignored; only the first two bytes appear on the line.
- `clear` at bit 3 of 0x5A with 0x77 buffered:
  - Next cycle `serial_out`=1, `tx_ready`=1, `tx_busy`=0.
  - No `byte_sent`; 0x77 is never sent.
- `n_rst`=0 mid-byte, then re-release: all outputs at reset values; a fresh load of 0x01 transmits correctly from bit0.
